l2_cache_arb: RTL and testbench
===============================

L2_CACHE_ARB -- requirements
Module: l2_cache_arb

Interface
REQ-001 The block SHALL take parameter NUM_REQUESTERS, default `NUM_CORES: number of core request ports.
REQ-002 The block SHALL take parameter STARVE_LIMIT, default 8: maximum consecutive fill grants while any core request waits (used only with the feature in REQ-024).
REQ-003 The block SHALL provide clk, in, 1: sole clock, rising edge.
REQ-004 The block SHALL provide reset, in, 1: asynchronous, active-low reset; 0 resets the block.
REQ-005 The block SHALL provide l2i_request, in, l2req_packet_t[NUM_REQUESTERS]: core requests; .valid qualifies each.
REQ-006 The block SHALL provide l2_request_ack, out, [NUM_REQUESTERS]: one-hot, core request consumed this cycle.
REQ-007 The block SHALL provide l2bi_request, in, l2req_packet_t: restarted miss from the bus interface, qualified by .valid.
REQ-008 The block SHALL provide l2bi_data_from_memory, in, `CACHE_LINE_BITS: fill line accompanying l2bi_request.
REQ-009 The block SHALL provide l2bi_stall, in, 1: miss queue full; new core requests are blocked.
REQ-010 The block SHALL provide l2a_request, out, l2req_packet_t: registered request to the tag stage.
REQ-011 The block SHALL provide l2a_data_from_memory, out, `CACHE_LINE_BITS: registered fill data.
REQ-012 The block SHALL provide l2a_is_l2_fill, out, 1: registered, l2a_request is a fill.

Function
REQ-013 Fills SHALL take priority: when l2bi_request.valid=1, l2bi_request is issued, l2_request_ack=0, and l2a_is_l2_fill=1 the next cycle.
REQ-014 With no fill and l2bi_stall=0, the block SHALL grant one valid core by round-robin, starting at the index after the last granted core and wrapping from NUM_REQUESTERS-1 to 0.
REQ-015 l2_request_ack SHALL be combinational in the grant cycle; a core holds its request until it sees ack=1.
REQ-016 Latency SHALL be exactly one cycle: a request granted in cycle N appears on l2a_* in cycle N+1.
REQ-017 When nothing is granted, l2a_request.valid SHALL be 0 the next cycle and l2a_is_l2_fill SHALL be 0.
REQ-018 l2bi_stall=1 SHALL block all core grants but SHALL NOT block fills.
REQ-019 The round-robin pointer SHALL update only on a core grant; fill cycles and idle cycles leave it unchanged.
REQ-020 The block SHALL never assert more than one ack bit per cycle.
REQ-021 l2a_data_from_memory SHALL load only on fill issue; otherwise it holds its previous value.

Reset
REQ-022 While reset=0: l2a_request=0, l2a_is_l2_fill=0, l2a_data_from_memory=0, the round-robin pointer points at index NUM_REQUESTERS-1 (so core 0 is first), and the starvation counter=0.
REQ-023 l2_request_ack SHALL be 0 during reset; a request in flight when reset asserts is dropped.

Configuration
REQ-024 With macro L2_ARB_ANTI_STARVE_EN defined, a counter SHALL increment on each fill grant made while any unstalled core is valid, and clear on any core grant. When the counter equals STARVE_LIMIT, the next cycle SHALL grant a core instead of the fill; that fill is held and not acked. Without the macro, the counter is absent and fills always win.

Structure
REQ-025 l2req_packet_t, `NUM_CORES and `CACHE_LINE_BITS SHALL come from the shared defines package; the block adds no new shared typedefs.
REQ-026 Round-robin selection SHALL be a sub-module, rr_arbiter (request vector, update enable, one-hot grant), reusable elsewhere in the design.

Verification
REQ-027 After reset, cores 0, 1 and 2 are all valid continuously: acks go 0,1,2,0 on consecutive cycles, and l2a_request.id follows one cycle later.
REQ-028 A fill and core 1 are valid in the same cycle: the fill issues with l2a_is_l2_fill=1, ack=0, and core 1 is acked the following cycle.
REQ-029 l2bi_stall=1 while cores are valid and a fill arrives: the fill issues, no core ack occurs, and grants resume the cycle after the stall drops.
REQ-030 With L2_ARB_ANTI_STARVE_EN, STARVE_LIMIT=8, continuous fills and core 0 valid: core 0 is acked on the 9th cycle, then fills resume.
REQ-031 Reset drops to 0 in the middle of a grant stream: outputs go to 0 asynchronously, and after release the first grant goes to core 0.
REQ-032 Only the highest-index core requests: it is acked, and the next grant wraps to core 0 when core 0 requests.

Source files
------------

// File: rtl/l2_cache_arb_pkg.sv
// ----------------------------------------------------------------------------
// l2_cache_arb_pkg
// Shared L2 request definitions. These are used by the L2 arbiter, the cores
// and the bus interface.
//   `NUM_CORES        number of core request ports (overridable on the command line)
//   `CACHE_LINE_BITS  width of one cache line (overridable on the command line)
//   l2req_packet_t    request packet: valid / id / op / address
// ----------------------------------------------------------------------------
`ifndef NUM_CORES
`define NUM_CORES 4
`endif
`ifndef CACHE_LINE_BITS
`define CACHE_LINE_BITS 512
`endif

package l2_cache_arb_pkg;

   localparam int NUM_CORES       = `NUM_CORES;
   localparam int CACHE_LINE_BITS = `CACHE_LINE_BITS;
   localparam int ID_BITS         = 4;
   localparam int ADDR_BITS       = 32;

   typedef enum logic [2:0] {
      OP_LOAD      = 3'd0,
      OP_STORE     = 3'd1,
      OP_FLUSH     = 3'd2,
      OP_IINVAL    = 3'd3,
      OP_DINVAL    = 3'd4,
      OP_SYNCLOAD  = 3'd5,
      OP_SYNCSTORE = 3'd6
   } l2_op_t;

   typedef struct packed {
      logic                 valid;
      logic [ID_BITS-1:0]   id;
      l2_op_t               op;
      logic [ADDR_BITS-1:0] address;
   } l2req_packet_t;

endpackage

// File: rtl/l2_cache_arb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Generic round-robin arbiter. The search for a winner starts at the index
// after the last winner and wraps from N-1 to 0. The pointer moves only when
// update_en is high and something was granted.
//   clk, rst_n  clock / asynchronous active-low reset (pointer -> N-1, so
//               index 0 is favoured first)
//   request     request vector
//   update_en   commit the current winner as the new "last granted"
//   grant       one-hot grant (combinational)
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] request,
   input  logic         update_en,
   output logic [N-1:0] grant
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N - 1);

   logic [PTR_W-1:0] last_q;
   logic [PTR_W-1:0] last_d;
   logic [PTR_W-1:0] win_idx;
   logic [PTR_W-1:0] cand;
   logic             found;

   // Walk the candidates last+1 .. last+N (mod N). The first requester found wins.
   always_comb begin
      grant   = '0;
      win_idx = last_q;
      cand    = '0;
      found   = 1'b0;
      for (int i = 1; i <= N; i++) begin
         cand = PTR_W'((int'(last_q) + i) % N);
         if (!found && request[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            win_idx     = cand;
         end
      end
      last_d = (update_en && found) ? win_idx : last_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= LAST_IDX;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/l2_cache_arb.sv
// ----------------------------------------------------------------------------
// l2_cache_arb
// Front-end arbiter of the L2 pipeline. Each cycle it picks one request from
// either the bus-interface restart/fill path or one of the cores, and passes
// that request to the tag stage through a single register stage.
// Fills have priority. Cores are served round-robin and are blocked while the
// miss queue is full (l2bi_stall).
// Optional feature: L2_ARB_ANTI_STARVE_EN. When this macro is defined, a core
// is forced through after STARVE_LIMIT consecutive fill grants made while a
// core was waiting.
// Ports:
//   clk, reset             clock / asynchronous active-low reset
//   l2i_request[]          core requests (.valid qualified)
//   l2_request_ack         one-hot combinational ack to the granted core
//   l2bi_request           restarted miss / fill from the bus interface
//   l2bi_data_from_memory  fill line accompanying l2bi_request
//   l2bi_stall             miss queue full; blocks core grants only
//   l2a_request            registered request to the tag stage
//   l2a_data_from_memory   registered fill line (loads only on a fill)
//   l2a_is_l2_fill         registered: l2a_request is a fill
// ----------------------------------------------------------------------------
module l2_cache_arb
   import l2_cache_arb_pkg::*;
#(
   parameter int NUM_REQUESTERS = `NUM_CORES,
   parameter int STARVE_LIMIT   = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  l2req_packet_t               l2i_request [NUM_REQUESTERS],
   output logic [NUM_REQUESTERS-1:0]   l2_request_ack,
   input  l2req_packet_t               l2bi_request,
   input  logic [`CACHE_LINE_BITS-1:0] l2bi_data_from_memory,
   input  logic                        l2bi_stall,
   output l2req_packet_t               l2a_request,
   output logic [`CACHE_LINE_BITS-1:0] l2a_data_from_memory,
   output logic                        l2a_is_l2_fill
);

   logic [NUM_REQUESTERS-1:0] core_req;
   logic [NUM_REQUESTERS-1:0] arb_grant;
   logic [NUM_REQUESTERS-1:0] core_grant;
   logic                      fill_win;
   l2req_packet_t             core_pkt;

   l2req_packet_t               req_q, req_d;
   logic                        fill_q, fill_d;
   logic [`CACHE_LINE_BITS-1:0] data_q, data_d;

   // A core counts as requesting only while the miss queue can accept it.
   for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_core_req
      assign core_req[gi] = l2i_request[gi].valid & ~l2bi_stall;
   end

`ifdef L2_ARB_ANTI_STARVE_EN
   localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             starve_force;

   // When the limit is reached and a core is waiting, that core takes the slot.
   // The fill stays on l2bi_request and is issued on a later cycle.
   assign starve_force = (starve_cnt_q == CNT_W'(STARVE_LIMIT)) && (|core_req);
   assign fill_win     = l2bi_request.valid && !starve_force;

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (|core_grant) begin
         starve_cnt_d = '0;
      end else if (fill_win && (|core_req)) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   logic limit_unused;
   assign limit_unused = (STARVE_LIMIT != 0);
   assign fill_win     = l2bi_request.valid;
`endif

   // The pointer advances only on a real core grant. Fill and idle cycles leave it unchanged.
   rr_arbiter #(
      .N (NUM_REQUESTERS)
   ) u_rr_arbiter (
      .clk       (clk),
      .rst_n     (reset),
      .request   (core_req),
      .update_en (~fill_win),
      .grant     (arb_grant)
   );

   assign core_grant     = fill_win ? '0 : arb_grant;
   // Gate the ack with reset so that no core sees its request consumed while reset is asserted.
   assign l2_request_ack = core_grant & {NUM_REQUESTERS{reset}};

   always_comb begin
      core_pkt = '0;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         if (core_grant[i]) begin
            core_pkt = l2i_request[i];
         end
      end
   end

   always_comb begin
      req_d  = '0;
      fill_d = fill_win;
      data_d = data_q;
      if (fill_win) begin
         req_d  = l2bi_request;
         data_d = l2bi_data_from_memory;
      end else if (|core_grant) begin
         req_d = core_pkt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_q  <= '0;
         fill_q <= 1'b0;
         data_q <= '0;
      end else begin
         req_q  <= req_d;
         fill_q <= fill_d;
         data_q <= data_d;
      end
   end

   assign l2a_request          = req_q;
   assign l2a_is_l2_fill       = fill_q;
   assign l2a_data_from_memory = data_q;

endmodule

// File: tb/tb_l2_cache_arb.sv
// ----------------------------------------------------------------------------
// tb_l2_cache_arb
// Directed scoreboard bench for l2_cache_arb (NUM_REQUESTERS = `NUM_CORES = 4).
// Each step drives one cycle of stimulus and checks the combinational ack
// against the expected one-hot value. It then pushes the expected registered
// output into a queue, and pops and compares that entry after the next edge.
// ----------------------------------------------------------------------------
module tb_l2_cache_arb;
   import l2_cache_arb_pkg::*;

   localparam int N  = NUM_CORES;
   localparam int DW = CACHE_LINE_BITS;
   localparam int CW = (DW > 64) ? DW : 64;

   typedef struct packed {
      l2req_packet_t pkt;
      logic          fill;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   l2req_packet_t l2i_request [N];
   logic [N-1:0]  l2_request_ack;
   l2req_packet_t l2bi_request;
   logic [DW-1:0] l2bi_data_from_memory;
   logic          l2bi_stall;
   l2req_packet_t l2a_request;
   logic [DW-1:0] l2a_data_from_memory;
   logic          l2a_is_l2_fill;

   exp_t          exp_q [$];
   logic [DW-1:0] exp_data;
   int            n_cmp = 0;
   int            n_err = 0;

   always #5 clk = ~clk;

   l2_cache_arb #(
      .NUM_REQUESTERS (N),
      .STARVE_LIMIT   (8)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .l2i_request           (l2i_request),
      .l2_request_ack        (l2_request_ack),
      .l2bi_request          (l2bi_request),
      .l2bi_data_from_memory (l2bi_data_from_memory),
      .l2bi_stall            (l2bi_stall),
      .l2a_request           (l2a_request),
      .l2a_data_from_memory  (l2a_data_from_memory),
      .l2a_is_l2_fill        (l2a_is_l2_fill)
   );

   task automatic check_eq(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // One cycle: drive the inputs, check the ack, queue the expected output, then pop and compare it after the clock edge.
   task automatic step(input string tag, input logic [N-1:0] cv, input logic fv,
                       input logic stall, input logic [N-1:0] exp_ack);
      exp_t          e;
      logic [DW-1:0] fdata;
      for (int i = 0; i < N; i++) begin
         l2i_request[i].valid   = cv[i];
         l2i_request[i].id      = ID_BITS'(i);
         l2i_request[i].op      = OP_LOAD;
         l2i_request[i].address = $urandom;
      end
      for (int w = 0; w < DW / 32; w++) begin
         fdata[w*32 +: 32] = $urandom;
      end
      l2bi_request.valid    = fv;
      l2bi_request.id       = 4'hf;
      l2bi_request.op       = OP_STORE;
      l2bi_request.address  = $urandom;
      l2bi_data_from_memory = fdata;
      l2bi_stall            = stall;
      #1;
      check_eq({tag, " ack"}, CW'(l2_request_ack), CW'(exp_ack));
      e.pkt  = '0;
      e.fill = 1'b0;
      if (exp_ack != '0) begin
         for (int i = 0; i < N; i++) begin
            if (exp_ack[i]) e.pkt = l2i_request[i];
         end
      end else if (fv) begin
         e.pkt    = l2bi_request;
         e.fill   = 1'b1;
         exp_data = fdata;
      end
      e.data = exp_data;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_eq({tag, " req"},  CW'(l2a_request),          CW'(e.pkt));
      check_eq({tag, " fill"}, CW'(l2a_is_l2_fill),       CW'(e.fill));
      check_eq({tag, " data"}, CW'(l2a_data_from_memory), CW'(e.data));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      for (int i = 0; i < N; i++) begin
         l2i_request[i]       = '0;
         l2i_request[i].valid = (i < 3);
      end
      l2bi_request          = '0;
      l2bi_data_from_memory = '0;
      l2bi_stall            = 1'b0;
      exp_data              = '0;

      // While reset is asserted, cores are requesting, but no ack and no output must appear.
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst ack",  CW'(l2_request_ack),       '0);
      check_eq("rst req",  CW'(l2a_request),          '0);
      check_eq("rst fill", CW'(l2a_is_l2_fill),       '0);
      check_eq("rst data", CW'(l2a_data_from_memory), '0);
      #2 reset = 1'b1;

      // Cores 0..2 requesting continuously: grants go 0,1,2,0.
      step("rr0", 4'b0111, 1'b0, 1'b0, 4'b0001);
      step("rr1", 4'b0111, 1'b0, 1'b0, 4'b0010);
      step("rr2", 4'b0111, 1'b0, 1'b0, 4'b0100);
      step("rr3", 4'b0111, 1'b0, 1'b0, 4'b0001);

      // A fill beats core 1, and core 1 is served on the next cycle.
      step("fill_vs_c1", 4'b0010, 1'b1, 1'b0, 4'b0000);
      step("c1_after",   4'b0010, 1'b0, 1'b0, 4'b0010);

      // The stall blocks cores but not fills. Grants resume once the stall drops.
      step("stall_fill", 4'b0101, 1'b1, 1'b1, 4'b0000);
      step("stall_idle", 4'b0101, 1'b0, 1'b1, 4'b0000);
      step("unstall",    4'b0101, 1'b0, 1'b0, 4'b0100);

      // Highest index alone, then a wrap to core 0.
      step("hi_only", 4'b1000, 1'b0, 1'b0, 4'b1000);
      step("wrap",    4'b1001, 1'b0, 1'b0, 4'b0001);

      // Idle and fill-only cycles must not move the pointer (it still points at 0).
      step("idle0",     4'b0000, 1'b0, 1'b0, 4'b0000);
      step("fill_only", 4'b0000, 1'b1, 1'b0, 4'b0000);
      step("idle1",     4'b0000, 1'b0, 1'b0, 4'b0000);
      step("ptr_hold",  4'b0011, 1'b0, 1'b0, 4'b0010);

      // Continuous fills while core 0 waits.
`ifdef L2_ARB_ANTI_STARVE_EN
      for (int k = 1; k <= 8; k++) begin
         step($sformatf("starve%0d", k), 4'b0001, 1'b1, 1'b0, 4'b0000);
      end
      step("starve9",      4'b0001, 1'b1, 1'b0, 4'b0001);
      step("fill_resumes", 4'b0000, 1'b1, 1'b0, 4'b0000);
`else
      for (int k = 1; k <= 9; k++) begin
         step($sformatf("fillwins%0d", k), 4'b0001, 1'b1, 1'b0, 4'b0000);
      end
      step("c0_after_fills", 4'b0001, 1'b0, 1'b0, 4'b0001);
`endif

      // Reset in the middle of a grant stream: outputs clear at once, and core 0 is first after release.
      step("pre_rst", 4'b0110, 1'b0, 1'b0, 4'b0010);
      #2 reset = 1'b0;
      #1;
      check_eq("mid_rst ack",  CW'(l2_request_ack),       '0);
      check_eq("mid_rst req",  CW'(l2a_request),          '0);
      check_eq("mid_rst fill", CW'(l2a_is_l2_fill),       '0);
      check_eq("mid_rst data", CW'(l2a_data_from_memory), '0);
      exp_data = '0;
      @(posedge clk);
      #3 reset = 1'b1;
      step("post_rst", 4'b0111, 1'b0, 1'b0, 4'b0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
